// File: rtl/instruction_fetch.sv
// Instruction fetch front end: drives the PC into a synchronous-read memory,
// tracks the single in-flight read, and buffers returned words in a 2-deep FIFO.
module instruction_fetch #(
  parameter int              DWIDTH   = 32,
  parameter int              MEMDEPTH = 1024,
  parameter int              AWIDTH   = $clog2(MEMDEPTH),
  parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DWIDTH-1:0] addressOut,
  input  logic [DWIDTH-1:0] instructionIn,
  input  logic              redirectValid,
  input  logic [DWIDTH-1:0] redirectPc,
  output logic              instrValid,
  input  logic              instrReady,
  output logic [DWIDTH-1:0] instrOut,
  output logic [DWIDTH-1:0] pcOut
);

  typedef struct packed {
    logic [DWIDTH-1:0] instr;
    logic [DWIDTH-1:0] pc;
  } entry_t;

  entry_t [1:0]      fifo;
  logic [1:0]        count;
  logic [DWIDTH-1:0] fetchPc;
  logic [DWIDTH-1:0] inflightPc;
  logic              inflight;

  logic       pop, push, issue, wrIdx;
  logic [2:0] credit;

  assign pop    = instrValid && instrReady;
  assign push   = inflight;
  // Slots already promised to buffered or in-flight words, net of this cycle's pop.
  assign credit = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue  = reset && !redirectValid && (credit < 3'd2);
  // Pushed word lands behind whatever survives this cycle's pop.
  assign wrIdx  = (count == 2'd2) || (count == 2'd1 && !pop);

  assign instrValid = (count != 2'd0);
  assign instrOut   = fifo[0].instr;
  assign pcOut      = fifo[0].pc;
  assign addressOut = {{(DWIDTH-AWIDTH){1'b0}}, fetchPc[AWIDTH+1:2]};

  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirectPc[1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetchPc    <= RESET_PC;
      inflight   <= 1'b0;
      inflightPc <= '0;
      count      <= 2'd0;
      fifo       <= '0;
    end else if (redirectValid) begin
      // Flush: the word returning next cycle belongs to the old path.
      fetchPc  <= {redirectPc[DWIDTH-1:2], 2'b00};
      inflight <= 1'b0;
      count    <= 2'd0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflightPc <= fetchPc;
        fetchPc    <= fetchPc + DWIDTH'(4);
      end
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop)
        fifo[0] <= fifo[1];
      if (push)
        fifo[wrIdx] <= '{instr: instructionIn, pc: inflightPc};
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch: expected {pc, instr} stream
// is generated from the sequential-fetch / redirect / reset rules.
module tb_instruction_fetch;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        reset, redirectValid, instrReady, instrValid;
  logic [31:0] addressOut, instructionIn, redirectPc, instrOut, pcOut;

  instruction_fetch #(.DWIDTH(32), .MEMDEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .addressOut(addressOut), .instructionIn(instructionIn),
    .redirectValid(redirectValid), .redirectPc(redirectPc), .instrValid(instrValid),
    .instrReady(instrReady), .instrOut(instrOut), .pcOut(pcOut)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];
  always @(posedge clk) instructionIn <= mem[addressOut[9:0]];

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t        q[$];
  exp_t        e;
  logic [31:0] nxt;
  int          checks = 0, errors = 0;
  bit          mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, then advance the expected stream for that cycle's reset/redirect.
  task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    reset = rst; redirectValid = rv; redirectPc = rpc; instrReady = rdy;
    @(posedge clk); #1;
    if (!rst) begin
      q.delete(); nxt = RPC;
    end else if (rv) begin
      q.delete(); nxt = {rpc[31:2], 2'b00};
    end
    while (q.size() < 4) begin
      q.push_back('{pc: nxt, instr: mem[nxt[11:2]]});
      nxt += 32'd4;
    end
  endtask

  // Monitor: transfers against the scoreboard, head stability, and fill-gap watchdog.
  bit          hold = 0;
  logic [31:0] hpc, hins;
  int          low = 0;
  always @(negedge clk) if (mon_en) begin
    if (hold) begin
      chk("hold_valid", {31'b0, instrValid}, 32'd1);
      chk("hold_pc", pcOut, hpc);
      chk("hold_instr", instrOut, hins);
    end
    hold = reset && !redirectValid && instrValid && !instrReady;
    hpc  = pcOut;
    hins = instrOut;
    if (reset && instrValid && instrReady) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL xfer_unexpected: got pc %h expected no transfer", pcOut);
      end else begin
        e = q.pop_front();
        chk("xfer_pc", pcOut, e.pc);
        chk("xfer_instr", instrOut, e.instr);
      end
    end
    if (!reset || redirectValid) low = 0;
    else if (!instrValid) begin
      low++;
      if (low > 3) begin
        checks++; errors++;
        $display("FAIL fetch_stall: got %0d empty cycles expected at most 3", low);
        low = 0;
      end
    end else low = 0;
  end

  int gaps;
  logic [31:0] frozen;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + i;
    nxt = RPC;

    // Reset state
    repeat (3) step(0, 0, 0, 1);
    mon_en = 1;
    chk("rst_valid", {31'b0, instrValid}, 0);
    chk("rst_addr", addressOut, RPC >> 2);
    chk("rst_instr", instrOut, 0);
    chk("rst_pc", pcOut, 0);

    // First fetch latency and gapless stream
    step(1, 0, 0, 1);
    chk("lat_t1_valid", {31'b0, instrValid}, 0);
    step(1, 0, 0, 1);
    chk("lat_t2_valid", {31'b0, instrValid}, 1);
    chk("lat_t2_pc", pcOut, 0);
    gaps = 0;
    repeat (20) begin
      step(1, 0, 0, 1);
      if (!instrValid) gaps++;
    end
    chk("stream_gaps", gaps, 0);

    // Backpressure: address must freeze once the FIFO and in-flight slot are full
    repeat (3) step(1, 0, 0, 0);
    frozen = addressOut;
    repeat (2) step(1, 0, 0, 0);
    chk("bp_addr_frozen", addressOut, frozen);
    chk("bp_valid", {31'b0, instrValid}, 1);
    repeat (10) step(1, 0, 0, 1);

    // Redirect coincident with the pop of PC 0x10
    repeat (2) step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    repeat (5) step(1, 0, 0, 1);
    chk("redir_pre_pc", pcOut, 32'h10);
    step(1, 1, 32'h40, 1);
    chk("redir_t1_valid", {31'b0, instrValid}, 0);
    chk("redir_t1_addr", addressOut, 32'd16);
    step(1, 0, 0, 1);
    chk("redir_t2_valid", {31'b0, instrValid}, 0);
    step(1, 0, 0, 1);
    chk("redir_t3_valid", {31'b0, instrValid}, 1);
    chk("redir_t3_pc", pcOut, 32'h40);
    chk("redir_t3_instr", instrOut, 32'h110);

    // Redirect with a full FIFO, stalled decode and unaligned target
    repeat (3) step(1, 0, 0, 0);
    step(1, 1, 32'h43, 0);
    chk("redir2_flush", {31'b0, instrValid}, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("redir2_pc", pcOut, 32'h40);
    chk("redir2_instr", instrOut, 32'h110);

    // PC wrap
    step(1, 1, 32'hFFFF_FFFC, 1);
    chk("wrap_addr_hi", addressOut, 32'd1023);
    step(1, 0, 0, 1);
    chk("wrap_addr_lo", addressOut, 32'd0);
    step(1, 0, 0, 1);
    chk("wrap_pc_hi", pcOut, 32'hFFFF_FFFC);
    chk("wrap_instr_hi", instrOut, 32'h4FF);
    step(1, 0, 0, 1);
    chk("wrap_pc_lo", pcOut, 32'h0);
    chk("wrap_instr_lo", instrOut, 32'h100);

    // Reset with two buffered words
    repeat (4) step(1, 0, 0, 0);
    chk("mid_rst_pre_valid", {31'b0, instrValid}, 1);
    step(0, 0, 0, 0);
    chk("mid_rst_valid", {31'b0, instrValid}, 0);
    chk("mid_rst_addr", addressOut, RPC >> 2);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("mid_rst_restart_pc", pcOut, RPC);

    // Randomized traffic
    repeat (3000) begin
      logic rst, rv, rdy;
      logic [31:0] rpc;
      rst = ($urandom_range(0, 199) != 0);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = $urandom;
      rdy = ($urandom_range(0, 9) < 7);
      step(rst, rv, rpc, rdy);
    end
    repeat (6) step(1, 0, 0, 1);
    mon_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
